// File: rtl/vliw_wb_pkg.sv
// Shared types and defaults for the VLIW writeback controller.
// The load tag queue entry type is also defined here.
package vliw_wb_pkg;

  localparam int REG_AW   = 3;
  localparam int DATA_W   = 32;
  localparam int LQ_DEPTH = 4;

  // Fetch redirects here on an exception; the same flush squashes writeback.
  localparam logic [31:0] EXCEPTION_HANDLER_ADDRESS = 32'h0000_0100;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              live;
  } lq_entry_t;

  function automatic logic [(1 << REG_AW)-1:0] rdOneHot(input logic [REG_AW-1:0] rd);
    logic [(1 << REG_AW)-1:0] oneHot;
    oneHot = '0;
    oneHot[rd] = 1'b1;
    return oneHot;
  endfunction

endpackage

// File: rtl/lq_tag_fifo.sv
// In-order queue of outstanding load destinations with kill/flush of live bits.
// The caller gates push/pop; slots outside [head, tail) always hold live=0.
module lq_tag_fifo #(
  parameter int LQ_DEPTH = vliw_wb_pkg::LQ_DEPTH,
  parameter int REG_AW   = vliw_wb_pkg::REG_AW,
  localparam int PW      = $clog2(LQ_DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [REG_AW-1:0]        pushRd,
  input  logic                     pop,
  input  logic                     killEn,
  input  logic [REG_AW-1:0]        killRd,
  input  logic                     flush,
  output logic [CW-1:0]            count,
  output vliw_wb_pkg::lq_entry_t   head,
  output logic [(1 << REG_AW)-1:0] pendingMask
);
  import vliw_wb_pkg::*;

  lq_entry_t       entries [LQ_DEPTH];
  logic [PW-1:0]   headPtr;
  logic [PW-1:0]   tailPtr;

  assign head = entries[headPtr];

  // Pointers wrap naturally because LQ_DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        // A load issued alongside a flush belongs to the squashed stream.
        if (push && PW'(i) == tailPtr) begin
          entries[i] <= {pushRd, ~flush};
        end else if (pop && PW'(i) == headPtr) begin
          entries[i].live <= 1'b0;
        end else if (flush || (killEn && entries[i].rd == killRd)) begin
          entries[i].live <= 1'b0;
        end
      end
      if (push) tailPtr <= tailPtr + 1'b1;
      if (pop)  headPtr <= headPtr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    pendingMask = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (entries[i].live) pendingMask = pendingMask | rdOneHot(entries[i].rd);
    end
  end

endmodule

// File: rtl/vliw_writeback_ctrl.sv
// Writeback controller for both register-file write ports (ALU slot, memory slot).
// Registers ALU results, retires in-order load bytes, and resolves WAW between slots.
module vliw_writeback_ctrl #(
  parameter int LQ_DEPTH = vliw_wb_pkg::LQ_DEPTH,
  parameter int DATA_W   = vliw_wb_pkg::DATA_W,
  parameter int REG_AW   = vliw_wb_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_alu_valid,
  input  logic              ex_alu_regWrite,
  input  logic [REG_AW-1:0] ex_alu_rd,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ld_issue_valid,
  input  logic [REG_AW-1:0] ld_issue_rd,
  output logic              ld_issue_ready,
  input  logic              mem_rsp_valid,
  input  logic [7:0]        mem_rsp_data,
  input  logic              flush,
  output logic              alu_regWrite,
  output logic [REG_AW-1:0] alu_rd,
  output logic [DATA_W-1:0] alu_writeData,
  output logic              mem_regWrite,
  output logic [REG_AW-1:0] mem_rd,
  output logic [DATA_W-1:0] mem_writeData,
  output logic [7:0]        pending_mask,
  output logic              err_unexpected_rsp
);
  import vliw_wb_pkg::*;

  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic [CW-1:0] lqCount;
  lq_entry_t     lqHead;
  logic          aluAccept;
  logic          lqPush;
  logic          lqPop;
  logic          lqEmpty;
  logic          headRetires;

  // Load issue handshake: a load transfers on a cycle where ld_issue_valid and
  // ld_issue_ready are both high; ready depends only on occupancy, so a full
  // queue refuses even when a response frees a slot that same cycle.
  assign ld_issue_ready = lqCount < CW'(LQ_DEPTH);
  assign lqPush         = ld_issue_valid && ld_issue_ready;
  assign lqEmpty        = lqCount == '0;
  assign lqPop          = mem_rsp_valid && !lqEmpty;
  assign aluAccept      = ex_alu_valid && ex_alu_regWrite && !flush;

  // The head is killed by a same-cycle ALU write to its rd: the ALU write is younger.
  assign headRetires = lqPop && lqHead.live && !flush &&
                       !(aluAccept && lqHead.rd == ex_alu_rd);

  lq_tag_fifo #(
    .LQ_DEPTH (LQ_DEPTH),
    .REG_AW   (REG_AW)
  ) u_lq (
    .clk         (clk),
    .reset       (reset),
    .push        (lqPush),
    .pushRd      (ld_issue_rd),
    .pop         (lqPop),
    .killEn      (aluAccept),
    .killRd      (ex_alu_rd),
    .flush       (flush),
    .count       (lqCount),
    .head        (lqHead),
    .pendingMask (pending_mask)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_regWrite       <= 1'b0;
      alu_rd             <= '0;
      alu_writeData      <= '0;
      mem_regWrite       <= 1'b0;
      mem_rd             <= '0;
      mem_writeData      <= '0;
      err_unexpected_rsp <= 1'b0;
    end else begin
      alu_regWrite <= aluAccept;
      if (aluAccept) begin
        alu_rd        <= ex_alu_rd;
        alu_writeData <= ex_alu_result;
      end
      mem_regWrite <= headRetires;
      if (headRetires) begin
        mem_rd        <= lqHead.rd;
        mem_writeData <= {{(DATA_W-8){1'b0}}, mem_rsp_data};
      end
      if (mem_rsp_valid && lqEmpty) err_unexpected_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vliw_writeback_ctrl.sv
// Directed bench for vliw_writeback_ctrl: queue-based reference model checked
// every cycle, an expected memory-write queue, and hand-computed spot checks.
module tb_vliw_writeback_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_alu_valid, ex_alu_regWrite;
  logic [2:0]  ex_alu_rd;
  logic [31:0] ex_alu_result;
  logic        ld_issue_valid;
  logic [2:0]  ld_issue_rd;
  logic        ld_issue_ready;
  logic        mem_rsp_valid;
  logic [7:0]  mem_rsp_data;
  logic        flush;
  logic        alu_regWrite, mem_regWrite, err_unexpected_rsp;
  logic [2:0]  alu_rd, mem_rd;
  logic [31:0] alu_writeData, mem_writeData;
  logic [7:0]  pending_mask;

  vliw_writeback_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .ex_alu_valid       (ex_alu_valid),
    .ex_alu_regWrite    (ex_alu_regWrite),
    .ex_alu_rd          (ex_alu_rd),
    .ex_alu_result      (ex_alu_result),
    .ld_issue_valid     (ld_issue_valid),
    .ld_issue_rd        (ld_issue_rd),
    .ld_issue_ready     (ld_issue_ready),
    .mem_rsp_valid      (mem_rsp_valid),
    .mem_rsp_data       (mem_rsp_data),
    .flush              (flush),
    .alu_regWrite       (alu_regWrite),
    .alu_rd             (alu_rd),
    .alu_writeData      (alu_writeData),
    .mem_regWrite       (mem_regWrite),
    .mem_rd             (mem_rd),
    .mem_writeData      (mem_writeData),
    .pending_mask       (pending_mask),
    .err_unexpected_rsp (err_unexpected_rsp)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] rd;
    logic       live;
  } mq_t;

  mq_t         mq[$];
  mq_t         mHead;
  mq_t         mEnt;
  logic        mAluOk, mCanPush;
  logic        eAluWe = 1'b0, eMemWe = 1'b0, eErr = 1'b0;
  logic [2:0]  eAluRd = '0, eMemRd = '0;
  logic [31:0] eAluData = '0, eMemData = '0;

  function automatic logic [7:0] modelPending();
    logic [7:0] m;
    m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      eAluWe = 0; eAluRd = 0; eAluData = 0;
      eMemWe = 0; eMemRd = 0; eMemData = 0;
      eErr = 0;
    end else begin
      mAluOk   = ex_alu_valid && ex_alu_regWrite && !flush;
      mCanPush = mq.size() < 4;
      eMemWe   = 0;
      if (mem_rsp_valid) begin
        if (mq.size() == 0) eErr = 1;
        else begin
          mHead = mq.pop_front();
          if (mHead.live && !flush && !(mAluOk && mHead.rd == ex_alu_rd)) begin
            eMemWe = 1; eMemRd = mHead.rd; eMemData = {24'h0, mem_rsp_data};
          end
        end
      end
      for (int i = 0; i < mq.size(); i++) begin
        mEnt = mq[i];
        if (flush || (mAluOk && mEnt.rd == ex_alu_rd)) mEnt.live = 0;
        mq[i] = mEnt;
      end
      if (ld_issue_valid && mCanPush) mq.push_back({ld_issue_rd, !flush});
      eAluWe = mAluOk;
      if (mAluOk) begin eAluRd = ex_alu_rd; eAluData = ex_alu_result; end
    end
  end

  // ---------------- scoreboard: expected memory writes {rd, data} ----------------
  logic [34:0] exp_q[$];
  logic [34:0] expW;

  always @(negedge clk) begin
    chk("alu_regWrite", alu_regWrite, eAluWe);
    chk("alu_rd", alu_rd, eAluRd);
    chk("alu_writeData", alu_writeData, eAluData);
    chk("mem_regWrite", mem_regWrite, eMemWe);
    chk("mem_rd", mem_rd, eMemRd);
    chk("mem_writeData", mem_writeData, eMemData);
    chk("pending_mask", pending_mask, modelPending());
    chk("ld_issue_ready", ld_issue_ready, mq.size() < 4);
    chk("err_unexpected_rsp", err_unexpected_rsp, eErr);
    if (mem_regWrite === 1'b1) begin
      if (exp_q.size() == 0) chk("mem_write_unexpected", {mem_rd, mem_writeData}, 64'h0);
      else begin
        expW = exp_q.pop_front();
        chk("mem_write_seq", {mem_rd, mem_writeData}, expW);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_alu_valid = 0; ex_alu_regWrite = 0; ex_alu_rd = 0; ex_alu_result = 0;
    ld_issue_valid = 0; ld_issue_rd = 0;
    mem_rsp_valid = 0; mem_rsp_data = 0;
    flush = 0;
  endtask

  task automatic aluWr(input logic [2:0] rd, input logic [31:0] data);
    ex_alu_valid = 1; ex_alu_regWrite = 1; ex_alu_rd = rd; ex_alu_result = data;
  endtask

  task automatic load(input logic [2:0] rd);
    ld_issue_valid = 1; ld_issue_rd = rd;
  endtask

  task automatic rsp(input logic [7:0] d);
    mem_rsp_valid = 1; mem_rsp_data = d;
  endtask

  logic [7:0] pendUp[3]   = '{8'h02, 8'h06, 8'h0E};
  logic [7:0] pendDown[3] = '{8'h0C, 8'h08, 8'h00};

  // ---------------- directed stimulus ----------------
  initial begin
    idle();
    reset = 1;
    repeat (2) cyc();
    reset = 0;
    chk("reset_alu_we", alu_regWrite, 0);
    chk("reset_mem_we", mem_regWrite, 0);
    chk("reset_ready", ld_issue_ready, 1);
    chk("reset_pending", pending_mask, 0);
    chk("reset_err", err_unexpected_rsp, 0);

    // basic ALU write
    aluWr(5, 32'hDEADBEEF);
    cyc(); idle();
    chk("alu_basic_we", alu_regWrite, 1);
    chk("alu_basic_rd", alu_rd, 5);
    chk("alu_basic_data", alu_writeData, 32'hDEADBEEF);
    cyc();
    chk("alu_basic_drop", alu_regWrite, 0);
    chk("alu_basic_hold", alu_writeData, 32'hDEADBEEF);

    // in-order loads r1..r3
    for (int i = 0; i < 3; i++) begin
      load(3'(i + 1)); cyc();
      chk("load_order_pend_up", pending_mask, pendUp[i]);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      rsp(8'(8'h11 * (i + 1)));
      exp_q.push_back({3'(i + 1), 32'(8'h11 * (i + 1))});
      cyc();
      chk("load_order_pend_down", pending_mask, pendDown[i]);
    end
    idle();
    cyc();

    // full queue, then 5th load together with a response
    for (int i = 1; i <= 4; i++) begin load(3'(i)); cyc(); end
    chk("full_ready", ld_issue_ready, 0);
    chk("full_pending", pending_mask, 8'h1E);
    load(6); rsp(8'h44); exp_q.push_back({3'd1, 32'h44});
    cyc(); idle();
    chk("full_pop_ready", ld_issue_ready, 1);
    chk("full_pop_pending", pending_mask, 8'h1C);
    chk("full_pop_we", mem_regWrite, 1);
    for (int i = 2; i <= 4; i++) begin
      rsp(8'(8'h11 * (i + 3))); exp_q.push_back({3'(i), 32'(8'h11 * (i + 3))});
      cyc();
    end
    idle();
    cyc();
    chk("full_drained_pending", pending_mask, 0);

    // WAW: ALU write to r4 together with the r4 response
    load(4); cyc(); idle();
    chk("waw_pending", pending_mask, 8'h10);
    aluWr(4, 32'hCAFE0004); rsp(8'h99);
    cyc(); idle();
    chk("waw_alu_we", alu_regWrite, 1);
    chk("waw_alu_rd", alu_rd, 4);
    chk("waw_mem_we", mem_regWrite, 0);
    chk("waw_pending_clr", pending_mask, 0);
    // WAW against a non-head queued entry
    load(2); cyc(); load(5); cyc(); idle();
    aluWr(5, 32'h5); cyc(); idle();
    chk("waw_tail_pending", pending_mask, 8'h04);
    rsp(8'hAA); exp_q.push_back({3'd2, 32'hAA}); cyc();
    rsp(8'hBB); cyc(); idle();
    chk("waw_tail_mem_we", mem_regWrite, 0);
    chk("waw_tail_ready", ld_issue_ready, 1);

    // flush with two loads queued
    load(6); cyc();
    load(7); aluWr(2, 32'h2222_0000); cyc(); idle();
    chk("flush_pre_pending", pending_mask, 8'hC0);
    flush = 1; aluWr(3, 32'h3333);
    chk("flush_prior_alu_completes", alu_regWrite, 1);
    cyc(); idle();
    chk("flush_alu_dropped", alu_regWrite, 0);
    chk("flush_alu_rd_hold", alu_rd, 2);
    chk("flush_pending", pending_mask, 0);
    rsp(8'hD1); cyc();
    rsp(8'hD2); cyc(); idle();
    chk("flush_absorbed_ready", ld_issue_ready, 1);
    chk("flush_err", err_unexpected_rsp, 0);

    // async reset with three loads pending
    load(1); cyc(); load(2); cyc();
    load(3); aluWr(7, 32'h1234); cyc(); idle();
    chk("rst_pre_pending", pending_mask, 8'h0E);
    chk("rst_pre_alu_we", alu_regWrite, 1);
    reset = 1;
    #1;
    chk("rst_async_alu_we", alu_regWrite, 0);
    chk("rst_async_alu_rd", alu_rd, 0);
    chk("rst_async_alu_data", alu_writeData, 0);
    chk("rst_async_mem_rd", mem_rd, 0);
    chk("rst_async_pending", pending_mask, 0);
    chk("rst_async_ready", ld_issue_ready, 1);
    cyc();
    reset = 0;
    rsp(8'h55); cyc(); idle();
    chk("unexp_err_set", err_unexpected_rsp, 1);
    chk("unexp_no_write", mem_regWrite, 0);
    cyc();
    chk("unexp_err_sticky", err_unexpected_rsp, 1);

    // empty queue: push and response in the same cycle
    load(3); rsp(8'hC3); cyc(); idle();
    chk("empty_push_rsp_pending", pending_mask, 8'h08);
    chk("empty_push_rsp_we", mem_regWrite, 0);
    rsp(8'h3C); exp_q.push_back({3'd3, 32'h3C}); cyc(); idle();
    chk("empty_push_rsp_retire", mem_writeData, 32'h3C);
    cyc();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vliw_writeback_ctrl.md
Name: vliw_writeback_ctrl

Overview:
- Drives both write ports of the VLIW register file: the ALU slot (alu_regWrite/alu_rd/alu_writeData) and the memory slot (mem_regWrite/mem_rd/mem_writeData).
- Sits between EX/MEM and the register file.
- Registers ALU results and tracks outstanding loadb requests in an in-order load tag queue.
- Retires memory responses to the memory write port, resolves WAW ordering between slots, and publishes a pending-register mask for decode stall logic.

Parameters:
- LQ_DEPTH, 4, load tag queue entries (power of 2, ≥2)
- DATA_W, 32, register width
- REG_AW, 3, register index width (8 registers)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ex_alu_valid  in  1  ALU slot result valid this cycle
- ex_alu_regWrite  in  1  ALU instruction writes a register
- ex_alu_rd  in  REG_AW  ALU destination
- ex_alu_result  in  DATA_W  ALU result
- ld_issue_valid  in  1  loadb issued to memory this cycle
- ld_issue_rd  in  REG_AW  load destination
- ld_issue_ready  out  1  queue can accept a load (count < LQ_DEPTH)
- mem_rsp_valid  in  1  memory returns a load byte (in order)
- mem_rsp_data  in  8  loaded byte
- flush  in  1  squash pending writebacks (exception/redirect)
- alu_regWrite  out  1  to register file
- alu_rd  out  REG_AW  to register file
- alu_writeData  out  DATA_W  to register file
- mem_regWrite  out  1  to register file
- mem_rd  out  REG_AW  to register file
- mem_writeData  out  DATA_W  to register file
- pending_mask  out  8  bit r set while a live load to r is queued
- err_unexpected_rsp  out  1  sticky: response arrived with empty queue

Behaviour:
- Reset (async): queue empty, all live bits 0, all outputs 0, err_unexpected_rsp=0.
- ALU path, latency 1: if ex_alu_valid && ex_alu_regWrite && !flush at edge t, then in cycle t+1 alu_regWrite=1, alu_rd=ex_alu_rd, alu_writeData=ex_alu_result. Otherwise alu_regWrite=0 next cycle; rd/data hold their last value.
- Load queue: circular FIFO of {rd, live}, head/tail pointers plus count.
  - Push when ld_issue_valid && ld_issue_ready; the entry is live.
  - ld_issue_ready depends on count only. A push while full is dropped even if a pop occurs that cycle.
  - An ld_issue_valid while not ready is ignored. The issuer must hold.
- Response retire, latency 1: on mem_rsp_valid with count>0, pop the head.
  - If the head is live (after kill, below), then next cycle mem_regWrite=1, mem_rd=head.rd, mem_writeData={24'b0, mem_rsp_data}.
  - If the head is dead, pop with no write.
- mem_rsp_valid with count==0: ignored, no pop. err_unexpected_rsp sets and stays set until reset.
- Simultaneous push and pop: both occur and count is unchanged. An empty queue with push and rsp in the same cycle counts as an unexpected response; the push still happens.
- WAW kill: an accepted ALU write to rd clears live on every queued entry with the same rd, including the head popped that same cycle. The older load's write is therefore suppressed and the younger ALU write wins.
  - A load pushed in the same cycle is younger and stays live.
  - As a result, the registered alu_rd==mem_rd with both write enables is never produced.
- flush: clears all live bits. Entries remain so that in-flight responses are absorbed. It also drops same-cycle ALU and memory writes. Writes already registered (visible this cycle) complete.
- pending_mask: combinational OR of decoded rd over live entries, from current state.
- Pointers wrap modulo LQ_DEPTH.

Decomposition:
- Package vliw_wb_pkg: REG_AW, DATA_W, LQ_DEPTH defaults, the lq_entry type {rd, live}, and EXCEPTION_HANDLER_ADDRESS (shared with fetch).
- One sub-module, lq_tag_fifo: the circular queue with per-entry rd-match kill, flush-all-live, and pending_mask generation.
- The top level holds the output registers and the retire/kill glue.

Test Plan:
- Basic ALU write: ex_alu_valid=1, regWrite=1, rd=5, result=0xDEADBEEF → next cycle alu_regWrite=1, alu_rd=5, alu_writeData=0xDEADBEEF; the cycle after, 0.
- Load order: issue loads to r1, r2, r3; responses 0x11, 0x22, 0x33 → mem writes r1=0x11, r2=0x22, r3=0x33 in order. pending_mask goes 0x0E→0x0C→0x08→0x00.
- Full queue: issue 4 loads → ld_issue_ready=0. A 5th load plus a response in the same cycle → pop only, count=3, ready=1 next cycle.
- WAW: load r4 queued; ALU write r4 in the same cycle as the r4 response → alu_regWrite=1 with r4, mem_regWrite=0, pending_mask bit4 cleared.
- Flush: 2 loads queued, flush=1 with an ALU write → no ALU write. The 2 later responses pop with mem_regWrite=0 and pending_mask=0 after flush.
- Async reset: assert reset mid-stream with 3 loads pending → all outputs 0 immediately, ready=1. A response after reset sets err_unexpected_rsp=1.
